frogger_qsys_otg_hpi_int: RTL

Avalon-MM slave input port that brings the CY7C67200 OTG HPI interrupt line (and any other HPI status inputs) into the Nios II system. It synchronises the external pins, exposes their level, latches selected edges in a sticky capture register and raises a maskable interrupt. It is the input-side counterpart of the HPI control output PIOs and sits on the same Avalon bus at zero read latency.

---
 rtl/frogger_qsys_otg_hpi_int_pkg.sv | 13 +
 rtl/frogger_qsys_sync2.sv | 26 ++
 rtl/frogger_qsys_otg_hpi_int.sv | 87 ++++++++
 3 files changed

// File: rtl/frogger_qsys_otg_hpi_int_pkg.sv
// Shared constants for the OTG HPI interrupt input PIO: the register map and
// the edge-capture encodings.
package frogger_qsys_otg_hpi_int_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int unsigned EDGE_RISING  = 0;
    localparam int unsigned EDGE_FALLING = 1;
    localparam int unsigned EDGE_ANY     = 2;

endpackage

// File: rtl/frogger_qsys_sync2.sv
// Two-flop synchroniser for asynchronous input pins; both stages reset to 0.
module frogger_qsys_sync2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/frogger_qsys_otg_hpi_int.sv
// Avalon-MM input PIO for the CY7C67200 HPI interrupt: synchronised level,
// sticky edge capture with write-1-to-clear, and a masked level interrupt.
module frogger_qsys_otg_hpi_int
    import frogger_qsys_otg_hpi_int_pkg::*;
#(
    parameter int unsigned WIDTH     = 1,
    parameter int unsigned EDGE_TYPE = EDGE_RISING
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] s3_q;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic             wr_en;
    logic             unused_wdata;

    frogger_qsys_sync2 #(
        .WIDTH (WIDTH)
    ) u_sync (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .d_i    (in_port),
        .q_o    (s2)
    );

    assign wr_en        = chipselect && !write_n;
    assign unused_wdata = ^writedata;

    always_comb begin
        if (EDGE_TYPE == EDGE_FALLING) begin
            edge_det = ~s2 & s3_q;
        end else if (EDGE_TYPE == EDGE_ANY) begin
            edge_det = s2 ^ s3_q;
        end else begin
            edge_det = s2 & ~s3_q;
        end
    end

    always_comb begin
        irqmask_d = irqmask_q;
        edgecap_d = edgecap_q;
        if (wr_en && address == ADDR_IRQMASK) begin
            irqmask_d = writedata[WIDTH-1:0];
        end
        if (wr_en && address == ADDR_EDGECAP) begin
            edgecap_d = edgecap_q & ~writedata[WIDTH-1:0];
        end
        // A new edge overrides a coincident clear.
        edgecap_d = edgecap_d | edge_det;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s3_q      <= '0;
            irqmask_q <= '0;
            edgecap_q <= '0;
        end else begin
            s3_q      <= s2;
            irqmask_q <= irqmask_d;
            edgecap_q <= edgecap_d;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:    readdata[WIDTH-1:0] = s2;
            ADDR_IRQMASK: readdata[WIDTH-1:0] = irqmask_q;
            ADDR_EDGECAP: readdata[WIDTH-1:0] = edgecap_q;
            default:      readdata = '0;
        endcase
    end

    assign irq = |(edgecap_q & irqmask_q);

endmodule
